// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared op codes, FSM states and op classification helpers for mem_stage
// Purpose: internal op_I codes for RV32I loads/stores, the MEM FSM state encoding,
//          and small helpers that classify an op and detect misaligned addresses.
// Ports:   none (package)
package mem_stage_pkg;

   localparam int OP_BITS = 6;

   // op_I codes consumed by the memory stage; ADD_I stands in for any non-memory op
   localparam logic [OP_BITS-1:0] ADD_I = 6'h01;
   localparam logic [OP_BITS-1:0] LB_I  = 6'h20;
   localparam logic [OP_BITS-1:0] LH_I  = 6'h21;
   localparam logic [OP_BITS-1:0] LW_I  = 6'h22;
   localparam logic [OP_BITS-1:0] LBU_I = 6'h23;
   localparam logic [OP_BITS-1:0] LHU_I = 6'h24;
   localparam logic [OP_BITS-1:0] SB_I  = 6'h25;
   localparam logic [OP_BITS-1:0] SH_I  = 6'h26;
   localparam logic [OP_BITS-1:0] SW_I  = 6'h27;

   // MEM FSM state encoding
   localparam logic IDLE = 1'b0;
   localparam logic REQ  = 1'b1;

   function automatic logic is_load_op(input logic [OP_BITS-1:0] op);
      return (op == LB_I) || (op == LH_I) || (op == LW_I) || (op == LBU_I) || (op == LHU_I);
   endfunction

   function automatic logic is_store_op(input logic [OP_BITS-1:0] op);
      return (op == SB_I) || (op == SH_I) || (op == SW_I);
   endfunction

   function automatic logic is_mem_op(input logic [OP_BITS-1:0] op);
      return is_load_op(op) || is_store_op(op);
   endfunction

   // Word ops need addr[1:0]==0, half ops need addr[0]==0; byte ops never misalign
   function automatic logic is_misaligned(input logic [OP_BITS-1:0] op, input logic [1:0] lo);
      logic word_op;
      logic half_op;
      word_op = (op == LW_I) || (op == SW_I);
      half_op = (op == LH_I) || (op == LHU_I) || (op == SH_I);
      return (word_op && (lo != 2'b00)) || (half_op && lo[0]);
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - formats a raw memory word into the RV32I load result
// Purpose: selects the byte/half addressed by lo from rdata and sign- or zero-extends it.
// Ports:   op    in  load op_I code
//          lo    in  effective address bits [1:0]
//          rdata in  full word returned by data memory
//          value out formatted load value
module mem_load_align
   import mem_stage_pkg::*;
#(
   parameter int DBITS = 32
) (
   input  logic [OP_BITS-1:0] op,
   input  logic [1:0]         lo,
   input  logic [DBITS-1:0]   rdata,
   output logic [DBITS-1:0]   value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      case (op)
         LB_I:    value = {{(DBITS-8){byte_sel[7]}}, byte_sel};
         LBU_I:   value = {{(DBITS-8){1'b0}}, byte_sel};
         LH_I:    value = {{(DBITS-16){half_sel[15]}}, half_sel};
         LHU_I:   value = {{(DBITS-16){1'b0}}, half_sel};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: RV32I loads/stores over a req/ack data port
// Purpose: consumes the AGEX latch, performs loads/stores with variable memory latency,
//          stalls upstream while an access is outstanding and produces the MEM latch.
// Ports:   clk, reset (async, active-low)
//          agex_*     in  AGEX latch (valid, op, pc, inst_count, aluout, st_data, wr_reg, wregno)
//          mem_stall  out hold AGEX and upstream this cycle
//          dmem_*     req/we/addr/wdata/be out (registered), ack/rdata in
//          mem_*      out MEM latch (valid, pc, inst_count, result, wr_reg, wregno, misalign)
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DBITS     = 32,
   parameter int REGNOBITS = 5,
   parameter int IOPBITS   = OP_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 agex_valid,
   input  logic [IOPBITS-1:0]   agex_op,
   input  logic [DBITS-1:0]     agex_pc,
   input  logic [DBITS-1:0]     agex_inst_count,
   input  logic [DBITS-1:0]     agex_aluout,
   input  logic [DBITS-1:0]     agex_st_data,
   input  logic                 agex_wr_reg,
   input  logic [REGNOBITS-1:0] agex_wregno,
   output logic                 mem_stall,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [DBITS-1:0]     dmem_addr,
   output logic [DBITS-1:0]     dmem_wdata,
   output logic [3:0]           dmem_be,
   input  logic                 dmem_ack,
   input  logic [DBITS-1:0]     dmem_rdata,
   output logic                 mem_valid,
   output logic [DBITS-1:0]     mem_pc,
   output logic [DBITS-1:0]     mem_inst_count,
   output logic [DBITS-1:0]     mem_result,
   output logic                 mem_wr_reg,
   output logic [REGNOBITS-1:0] mem_wregno,
   output logic                 mem_misalign
);

   logic state_q, state_d;

   // Capture of the in-flight access
   logic [IOPBITS-1:0]   cap_op_q, cap_op_d;
   logic [1:0]           cap_lo_q, cap_lo_d;
   logic                 cap_wr_reg_q, cap_wr_reg_d;
   logic [REGNOBITS-1:0] cap_wregno_q, cap_wregno_d;
   logic [DBITS-1:0]     cap_pc_q, cap_pc_d;
   logic [DBITS-1:0]     cap_cnt_q, cap_cnt_d;

   // Registered data-memory port
   logic                 dmem_req_q, dmem_req_d;
   logic                 dmem_we_q, dmem_we_d;
   logic [DBITS-1:0]     dmem_addr_q, dmem_addr_d;
   logic [DBITS-1:0]     dmem_wdata_q, dmem_wdata_d;
   logic [3:0]           dmem_be_q, dmem_be_d;

   // MEM latch
   logic                 mem_valid_q, mem_valid_d;
   logic [DBITS-1:0]     mem_pc_q, mem_pc_d;
   logic [DBITS-1:0]     mem_cnt_q, mem_cnt_d;
   logic [DBITS-1:0]     mem_result_q, mem_result_d;
   logic                 mem_wr_reg_q, mem_wr_reg_d;
   logic [REGNOBITS-1:0] mem_wregno_q, mem_wregno_d;
   logic                 mem_misalign_q, mem_misalign_d;

   logic                 is_mem;
   logic                 misal;
   logic                 start_access;
   logic [DBITS-1:0]     load_value;
   logic [3:0]           st_be;
   logic [DBITS-1:0]     st_wdata;

   assign is_mem       = agex_valid && is_mem_op(agex_op);
   assign misal        = is_mem && is_misaligned(agex_op, agex_aluout[1:0]);
   assign start_access = is_mem && !misal;

   mem_load_align #(.DBITS(DBITS)) u_load_align (
      .op    (cap_op_q),
      .lo    (cap_lo_q),
      .rdata (dmem_rdata),
      .value (load_value)
   );

   // Store lane formatting: replicate data across lanes, enable only the addressed bytes
   always_comb begin
      st_be    = 4'b0000;
      st_wdata = '0;
      case (agex_op)
         SB_I: begin
            st_be    = 4'b0001 << agex_aluout[1:0];
            st_wdata = {4{agex_st_data[7:0]}};
         end
         SH_I: begin
            st_be    = agex_aluout[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{agex_st_data[15:0]}};
         end
         SW_I: begin
            st_be    = 4'b1111;
            st_wdata = agex_st_data;
         end
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_access) state_d = REQ;
         REQ:     if (dmem_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Stall output; never looks at dmem_rdata
   always_comb begin
      mem_stall = 1'b0;
      case (state_q)
         IDLE:    mem_stall = start_access;
         REQ:     mem_stall = !dmem_ack;
         default: mem_stall = 1'b0;
      endcase
   end

   // Datapath next values
   always_comb begin
      cap_op_d       = cap_op_q;
      cap_lo_d       = cap_lo_q;
      cap_wr_reg_d   = cap_wr_reg_q;
      cap_wregno_d   = cap_wregno_q;
      cap_pc_d       = cap_pc_q;
      cap_cnt_d      = cap_cnt_q;
      dmem_req_d     = dmem_req_q;
      dmem_we_d      = dmem_we_q;
      dmem_addr_d    = dmem_addr_q;
      dmem_wdata_d   = dmem_wdata_q;
      dmem_be_d      = dmem_be_q;
      // MEM latch defaults to a bubble
      mem_valid_d    = 1'b0;
      mem_pc_d       = mem_pc_q;
      mem_cnt_d      = mem_cnt_q;
      mem_result_d   = mem_result_q;
      mem_wr_reg_d   = 1'b0;
      mem_wregno_d   = mem_wregno_q;
      mem_misalign_d = 1'b0;

      if (state_q == IDLE) begin
         if (start_access) begin
            cap_op_d     = agex_op;
            cap_lo_d     = agex_aluout[1:0];
            cap_wr_reg_d = agex_wr_reg;
            cap_wregno_d = agex_wregno;
            cap_pc_d     = agex_pc;
            cap_cnt_d    = agex_inst_count;
            dmem_req_d   = 1'b1;
            dmem_we_d    = is_store_op(agex_op);
            dmem_addr_d  = {agex_aluout[DBITS-1:2], 2'b00};
            dmem_wdata_d = st_wdata;
            dmem_be_d    = st_be;
         end else begin
            // Non-mem op, bubble or misaligned access retires next cycle
            mem_valid_d    = agex_valid;
            mem_pc_d       = agex_pc;
            mem_cnt_d      = agex_inst_count;
            mem_result_d   = agex_aluout;
            mem_wr_reg_d   = agex_valid && agex_wr_reg && !misal;
            mem_wregno_d   = agex_wregno;
            mem_misalign_d = misal;
         end
      end else if (dmem_ack) begin
         dmem_req_d   = 1'b0;
         dmem_we_d    = 1'b0;
         dmem_be_d    = 4'b0000;
         mem_valid_d  = 1'b1;
         mem_pc_d     = cap_pc_q;
         mem_cnt_d    = cap_cnt_q;
         mem_wregno_d = cap_wregno_q;
         if (is_load_op(cap_op_q)) begin
            mem_result_d = load_value;
            mem_wr_reg_d = cap_wr_reg_q && (cap_wregno_q != '0);
         end else begin
            mem_result_d = {dmem_addr_q[DBITS-1:2], cap_lo_q};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_op_q       <= '0;
         cap_lo_q       <= '0;
         cap_wr_reg_q   <= 1'b0;
         cap_wregno_q   <= '0;
         cap_pc_q       <= '0;
         cap_cnt_q      <= '0;
         dmem_req_q     <= 1'b0;
         dmem_we_q      <= 1'b0;
         dmem_addr_q    <= '0;
         dmem_wdata_q   <= '0;
         dmem_be_q      <= 4'b0000;
         mem_valid_q    <= 1'b0;
         mem_pc_q       <= '0;
         mem_cnt_q      <= '0;
         mem_result_q   <= '0;
         mem_wr_reg_q   <= 1'b0;
         mem_wregno_q   <= '0;
         mem_misalign_q <= 1'b0;
      end else begin
         cap_op_q       <= cap_op_d;
         cap_lo_q       <= cap_lo_d;
         cap_wr_reg_q   <= cap_wr_reg_d;
         cap_wregno_q   <= cap_wregno_d;
         cap_pc_q       <= cap_pc_d;
         cap_cnt_q      <= cap_cnt_d;
         dmem_req_q     <= dmem_req_d;
         dmem_we_q      <= dmem_we_d;
         dmem_addr_q    <= dmem_addr_d;
         dmem_wdata_q   <= dmem_wdata_d;
         dmem_be_q      <= dmem_be_d;
         mem_valid_q    <= mem_valid_d;
         mem_pc_q       <= mem_pc_d;
         mem_cnt_q      <= mem_cnt_d;
         mem_result_q   <= mem_result_d;
         mem_wr_reg_q   <= mem_wr_reg_d;
         mem_wregno_q   <= mem_wregno_d;
         mem_misalign_q <= mem_misalign_d;
      end
   end

   assign dmem_req       = dmem_req_q;
   assign dmem_we        = dmem_we_q;
   assign dmem_addr      = dmem_addr_q;
   assign dmem_wdata     = dmem_wdata_q;
   assign dmem_be        = dmem_be_q;
   assign mem_valid      = mem_valid_q;
   assign mem_pc         = mem_pc_q;
   assign mem_inst_count = mem_cnt_q;
   assign mem_result     = mem_result_q;
   assign mem_wr_reg     = mem_wr_reg_q;
   assign mem_wregno     = mem_wregno_q;
   assign mem_misalign   = mem_misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed and randomized self-checking bench for mem_stage
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk;
   logic        reset;
   logic        agex_valid;
   logic [5:0]  agex_op;
   logic [31:0] agex_pc;
   logic [31:0] agex_inst_count;
   logic [31:0] agex_aluout;
   logic [31:0] agex_st_data;
   logic        agex_wr_reg;
   logic [4:0]  agex_wregno;
   logic        mem_stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        mem_valid;
   logic [31:0] mem_pc;
   logic [31:0] mem_inst_count;
   logic [31:0] mem_result;
   logic        mem_wr_reg;
   logic [4:0]  mem_wregno;
   logic        mem_misalign;

   int checks = 0;
   int errors = 0;

   mem_stage dut (
      .clk             (clk),
      .reset           (reset),
      .agex_valid      (agex_valid),
      .agex_op         (agex_op),
      .agex_pc         (agex_pc),
      .agex_inst_count (agex_inst_count),
      .agex_aluout     (agex_aluout),
      .agex_st_data    (agex_st_data),
      .agex_wr_reg     (agex_wr_reg),
      .agex_wregno     (agex_wregno),
      .mem_stall       (mem_stall),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_addr       (dmem_addr),
      .dmem_wdata      (dmem_wdata),
      .dmem_be         (dmem_be),
      .dmem_ack        (dmem_ack),
      .dmem_rdata      (dmem_rdata),
      .mem_valid       (mem_valid),
      .mem_pc          (mem_pc),
      .mem_inst_count  (mem_inst_count),
      .mem_result      (mem_result),
      .mem_wr_reg      (mem_wr_reg),
      .mem_wregno      (mem_wregno),
      .mem_misalign    (mem_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int op_size(input logic [5:0] op);
      if (op == LB_I || op == LBU_I || op == SB_I) return 1;
      if (op == LH_I || op == LHU_I || op == SH_I) return 2;
      if (op == LW_I || op == SW_I) return 4;
      return 0;
   endfunction

   function automatic bit op_store(input logic [5:0] op);
      return op == SB_I || op == SH_I || op == SW_I;
   endfunction

   function automatic logic [31:0] size_mask(input int sz);
      return (sz >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
   endfunction

   function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr,
                                            input logic [31:0] rdata);
      int sz;
      logic [31:0] m, v;
      sz = op_size(op);
      m  = size_mask(sz);
      v  = (rdata >> (8 * (addr % 4))) & m;
      if ((op == LB_I || op == LH_I) && v[8*sz-1]) v = v | ~m;
      return v;
   endfunction

   function automatic logic [3:0] ref_be(input logic [5:0] op, input logic [31:0] addr);
      int sz;
      sz = op_size(op);
      if (!op_store(op)) return 4'b0000;
      return 4'(((1 << sz) - 1) << (addr % 4));
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [5:0] op, input logic [31:0] st);
      int sz;
      sz = op_size(op);
      if (sz == 1) return (st & 32'hFF) * 32'h0101_0101;
      if (sz == 2) return (st & 32'hFFFF) * 32'h0001_0001;
      return st;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One instruction through MEM; entered and left just after a rising edge.
   // k = REQ cycles without ack before the ack cycle.
   task automatic do_inst(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] st,
                          input logic wr, input logic [4:0] rd, input int k,
                          input logic [31:0] rdata);
      int sz;
      bit mem_op, mis;
      logic [31:0] pc, cnt;
      sz     = op_size(op);
      mem_op = (sz != 0);
      mis    = mem_op && (addr % sz != 0);
      pc     = $urandom;
      cnt    = $urandom;
      agex_valid      = 1'b1;
      agex_op         = op;
      agex_pc         = pc;
      agex_inst_count = cnt;
      agex_aluout     = addr;
      agex_st_data    = st;
      agex_wr_reg     = wr;
      agex_wregno     = rd;
      dmem_ack        = 1'($urandom % 2);   // stale ack while idle
      dmem_rdata      = $urandom;
      @(negedge clk);
      chk("idle_stall", 32'(mem_stall), 32'(mem_op && !mis));
      chk("idle_req", 32'(dmem_req), 0);
      chk("idle_misalign", 32'(mem_misalign), 0);
      if (mem_op && !mis) begin
         @(posedge clk); #1;
         dmem_ack = 1'b0;
         for (int j = 0; j <= k; j++) begin
            if (j == k) begin
               dmem_ack   = 1'b1;
               dmem_rdata = rdata;
            end
            @(negedge clk);
            chk("req_req", 32'(dmem_req), 1);
            chk("req_we", 32'(dmem_we), 32'(op_store(op)));
            chk("req_addr", dmem_addr, addr & ~32'd3);
            chk("req_be", 32'(dmem_be), 32'(ref_be(op, addr)));
            if (op_store(op)) chk("req_wdata", dmem_wdata, ref_wdata(op, st));
            chk("req_stall", 32'(mem_stall), 32'(j != k));
            chk("req_bubble", 32'(mem_valid), 0);
            @(posedge clk); #1;
         end
         dmem_ack   = 1'b0;
         agex_valid = 1'b0;
         @(negedge clk);
         chk("ret_valid", 32'(mem_valid), 1);
         chk("ret_wr_reg", 32'(mem_wr_reg), 32'(!op_store(op) && wr && rd != 0));
         if (!op_store(op)) chk("ret_result", mem_result, ref_load(op, addr, rdata));
         chk("ret_wregno", 32'(mem_wregno), 32'(rd));
         chk("ret_pc", mem_pc, pc);
         chk("ret_cnt", mem_inst_count, cnt);
         chk("ret_misalign", 32'(mem_misalign), 0);
         chk("ret_req", 32'(dmem_req), 0);
      end else begin
         @(posedge clk); #1;
         agex_valid = 1'b0;
         dmem_ack   = 1'($urandom % 2);
         @(negedge clk);
         chk("pass_valid", 32'(mem_valid), 1);
         chk("pass_wr_reg", 32'(mem_wr_reg), 32'(!mis && wr));
         chk("pass_result", mem_result, addr);
         chk("pass_misalign", 32'(mem_misalign), 32'(mis));
         chk("pass_pc", mem_pc, pc);
         chk("pass_cnt", mem_inst_count, cnt);
         if (!mis) chk("pass_wregno", 32'(mem_wregno), 32'(rd));
         chk("pass_req", 32'(dmem_req), 0);
         chk("pass_stall", 32'(mem_stall), 0);
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
   endtask

   logic [5:0] op_tab [9];

   initial begin
      op_tab = '{ADD_I, LB_I, LH_I, LW_I, LBU_I, LHU_I, SB_I, SH_I, SW_I};
      reset = 1'b0;
      agex_valid = 1'b0; agex_op = '0; agex_pc = '0; agex_inst_count = '0;
      agex_aluout = '0; agex_st_data = '0; agex_wr_reg = 1'b0; agex_wregno = '0;
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      #3;
      chk("rst_valid", 32'(mem_valid), 0);
      chk("rst_req", 32'(dmem_req), 0);
      chk("rst_stall", 32'(mem_stall), 0);
      chk("rst_result", mem_result, 0);
      chk("rst_be", 32'(dmem_be), 0);
      chk("rst_misalign", 32'(mem_misalign), 0);
      @(posedge clk); #1;
      reset = 1'b1;                     // ack still high: stale ack after reset
      @(negedge clk);
      chk("stale_req", 32'(dmem_req), 0);
      chk("stale_stall", 32'(mem_stall), 0);
      @(posedge clk); #1;
      chk("stale_valid", 32'(mem_valid), 0);
      dmem_ack = 1'b0;

      // Directed cases
      do_inst(ADD_I, 32'h0000_1234, 32'h0, 1'b1, 5'd5, 0, 32'h0);
      do_inst(SW_I,  32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 5'd7, 3, 32'h0);
      do_inst(LB_I,  32'h0000_0103, 32'h0, 1'b1, 5'd3, 1, 32'h8000_0000);
      do_inst(LBU_I, 32'h0000_0103, 32'h0, 1'b1, 5'd3, 2, 32'h8000_0000);
      do_inst(LH_I,  32'h0000_0102, 32'h0, 1'b1, 5'd9, 1, 32'h8001_0000);
      do_inst(SH_I,  32'h0000_0102, 32'h0000_ABCD, 1'b0, 5'd0, 1, 32'h0);
      do_inst(LW_I,  32'h0000_0101, 32'h0, 1'b1, 5'd4, 1, 32'h0);
      do_inst(LW_I,  32'h0000_0104, 32'h0, 1'b1, 5'd0, 1, 32'h1234_5678);

      // Reset asserted while an access is outstanding
      agex_valid = 1'b1; agex_op = SW_I; agex_aluout = 32'h200; agex_st_data = 32'h55;
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_req_before", 32'(dmem_req), 1);
      #2;
      reset = 1'b0;
      agex_valid = 1'b0;
      #1;
      chk("abort_req_async", 32'(dmem_req), 0);
      chk("abort_stall", 32'(mem_stall), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      dmem_ack = 1'b1;
      @(negedge clk);
      chk("abort_ack_req", 32'(dmem_req), 0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      chk("abort_ack_valid", 32'(mem_valid), 0);
      @(posedge clk); #1;

      // Randomized instructions
      for (int n = 0; n < 80; n++) begin
         logic [5:0]  op;
         logic [31:0] addr;
         int sz;
         op   = op_tab[$urandom_range(0, 8)];
         sz   = op_size(op);
         addr = 32'h1000 + $urandom_range(0, 255);
         if (sz > 1 && ($urandom % 2 == 1)) addr = addr & ~32'(sz - 1);
         do_inst(op, addr, $urandom, 1'($urandom % 2), 5'($urandom % 8),
                 $urandom_range(1, 4), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
